// File: rtl/multicycle_maindec.sv
// multicycle_maindec
// Main control FSM for the multicycle MIPS datapath. Each instruction is
// walked through fetch, decode, execute, memory and writeback steps; the FSM
// drives every datapath enable and mux select and supplies the 2-bit aluop
// consumed by aludec. Memory steps hold until mem_ready so slow memories can
// stall the core.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (returns to FETCH)
//   op         instr[31:26]; used in DECODE and MEMADR only
//   mem_ready  memory completes the current access this cycle
//   iord, memwrite, irwrite, pcwrite, branch, pcsrc, alusrca, alusrcb,
//   aluop, regdst, memtoreg, regwrite   datapath controls
//   instr_done one-cycle pulse in the last cycle of each instruction
//   illegal_op one-cycle pulse in DECODE on an unsupported opcode
//   state      current state, for debug
module multicycle_maindec #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               branch,
  output logic [1:0]         pcsrc,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q;
  state_t state_d;

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state output decode; everything defaults to 0.
  always_comb begin
    state_d    = S_FETCH;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      S_FETCH: begin
        // IR load and PC+4 commit only once the fetch read completes.
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded.
        alusrcb = 2'b11;
        case (op)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW) begin
          state_d = S_MEMRD;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        // Write strobe stays up for the whole wait; the store retires on ready.
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: begin
        // Unused encodings recover to FETCH with all controls inactive.
        state_d = S_FETCH;
      end
    endcase
  end

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_maindec.sv
// Self-checking bench for multicycle_maindec: a path-based reference model
// compared every cycle, plus directed sequences with literal expectations.
module tb_multicycle_maindec;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'd0;
  logic       mem_ready = 1'b1;
  logic       iord, memwrite, irwrite, pcwrite, branch;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic       alusrca, regdst, memtoreg, regwrite, instr_done, illegal_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_err    = 0;
  logic chk_on = 1'b0;

  int cnt_irw, cnt_mw, cnt_done, cnt_ill, cnt_mtr;

  multicycle_maindec #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite),
    .branch(branch), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: after DECODE each opcode follows a fixed route of
  // states; FETCH, MEMRD and MEMWR hold until mem_ready.
  function automatic int route(input logic [5:0] o, input int k);
    int r;
    r = 0;
    case (o)
      6'b000000: r = (k == 0) ? 6 : (k == 1) ? 7 : 0;
      6'b100011: r = (k == 0) ? 2 : (k == 1) ? 3 : (k == 2) ? 4 : 0;
      6'b101011: r = (k == 0) ? 2 : (k == 1) ? 5 : 0;
      6'b000100: r = (k == 0) ? 8 : 0;
      6'b001000: r = (k == 0) ? 9 : (k == 1) ? 10 : 0;
      6'b000010: r = (k == 0) ? 11 : 0;
      default:   r = 0;
    endcase
    return r;
  endfunction

  int m_state = 0;
  int m_step  = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_state <= 0;
      m_step  <= 0;
    end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
      m_state <= m_state;
    end else if (m_state == 0) begin
      m_state <= 1;
      m_step  <= 0;
    end else begin
      m_state <= route(op, m_step);
      m_step  <= m_step + 1;
    end
  end

  // Expected control word {iord,memwrite,irwrite,pcwrite,branch,pcsrc,
  // alusrca,alusrcb,aluop,regdst,memtoreg,regwrite,instr_done,illegal_op}.
  function automatic logic [16:0] exp_vec(input int s, input logic mr, input logic [5:0] o);
    logic iord_e, mw_e, irw_e, pcw_e, br_e, asa_e, rd_e, mtr_e, rw_e, dn_e, il_e;
    logic [1:0] pcs_e, asb_e, aop_e;
    logic supported;
    {iord_e, mw_e, irw_e, pcw_e, br_e, asa_e, rd_e, mtr_e, rw_e, dn_e, il_e} = 11'd0;
    pcs_e = 2'b00; asb_e = 2'b00; aop_e = 2'b00;
    supported = (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) ||
                (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
    case (s)
      0:  begin asb_e = 2'b01; irw_e = mr; pcw_e = mr; end
      1:  begin asb_e = 2'b11; il_e = !supported; end
      2:  begin asa_e = 1'b1; asb_e = 2'b10; end
      3:  iord_e = 1'b1;
      4:  begin mtr_e = 1'b1; rw_e = 1'b1; dn_e = 1'b1; end
      5:  begin iord_e = 1'b1; mw_e = 1'b1; dn_e = mr; end
      6:  begin asa_e = 1'b1; aop_e = 2'b10; end
      7:  begin rd_e = 1'b1; rw_e = 1'b1; dn_e = 1'b1; end
      8:  begin asa_e = 1'b1; aop_e = 2'b01; pcs_e = 2'b01; br_e = 1'b1; dn_e = 1'b1; end
      9:  begin asa_e = 1'b1; asb_e = 2'b10; end
      10: begin rw_e = 1'b1; dn_e = 1'b1; end
      11: begin pcs_e = 2'b10; pcw_e = 1'b1; dn_e = 1'b1; end
      default: ;
    endcase
    return {iord_e, mw_e, irw_e, pcw_e, br_e, pcs_e, asa_e, asb_e, aop_e,
            rd_e, mtr_e, rw_e, dn_e, il_e};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare of DUT state and controls against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("model_state", {28'd0, state}, m_state);
        chk("model_ctrl",
            {15'd0, iord, memwrite, irwrite, pcwrite, branch, pcsrc, alusrca,
             alusrcb, aluop, regdst, memtoreg, regwrite, instr_done, illegal_op},
            {15'd0, exp_vec(m_state, mem_ready, op)});
      end
    end
  end

  // Apply one input vector per cycle and check the literal state sequence.
  task automatic seq(input string nm, input int n, input int ops[12],
                     input int mrs[12], input int sts[12]);
    cnt_irw = 0; cnt_mw = 0; cnt_done = 0; cnt_ill = 0; cnt_mtr = 0;
    for (int i = 0; i < n; i++) begin
      op        = ops[i][5:0];
      mem_ready = mrs[i][0];
      @(negedge clk);
      chk($sformatf("%s_state%0d", nm, i), {28'd0, state}, sts[i]);
      cnt_irw  += int'(irwrite);
      cnt_mw   += int'(memwrite && iord);
      cnt_done += int'(instr_done);
      cnt_ill  += int'(illegal_op);
      cnt_mtr  += int'(memtoreg);
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    // Reset held across several edges.
    rst = 1'b1; mem_ready = 1'b1; op = 6'd0;
    repeat (3) @(posedge clk);
    #2;
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_alusrcb", {30'd0, alusrcb}, 32'd1);
    chk("rst_irw_pcw", {30'd0, irwrite, pcwrite}, 32'd3);
    chk("rst_others", {23'd0, iord, memwrite, branch, pcsrc, alusrca, aluop,
                       regdst, memtoreg, regwrite, instr_done, illegal_op}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // R-type, mem_ready tied high; final FETCH cycle stalls to park in 0.
    seq("rtype", 5, '{0,0,0,0,0,0,0,0,0,0,0,0}, '{1,1,1,1,0,0,0,0,0,0,0,0},
        '{0,1,6,7,0,0,0,0,0,0,0,0});
    chk("rtype_done_cnt", cnt_done, 32'd1);

    // lw with 2 fetch waits and 3 read waits.
    seq("lw", 11, '{35,35,35,35,35,35,35,35,35,35,35,0},
        '{0,0,1,1,1,0,0,0,1,1,0,0}, '{0,0,0,1,2,3,3,3,3,4,0,0});
    chk("lw_irwrite_cnt", cnt_irw, 32'd1);
    chk("lw_memtoreg_cnt", cnt_mtr, 32'd1);
    chk("lw_done_cnt", cnt_done, 32'd1);

    // sw with 2 write waits.
    seq("sw", 7, '{43,43,43,43,43,43,43,0,0,0,0,0},
        '{1,1,1,0,0,1,0,0,0,0,0,0}, '{0,1,2,5,5,5,0,0,0,0,0,0});
    chk("sw_memwrite_cnt", cnt_mw, 32'd3);
    chk("sw_done_cnt", cnt_done, 32'd1);

    // beq followed by j.
    seq("beq_j", 7, '{4,4,4,2,2,2,2,0,0,0,0,0},
        '{1,1,1,1,1,1,0,0,0,0,0,0}, '{0,1,8,0,1,11,0,0,0,0,0,0});
    chk("beq_j_done_cnt", cnt_done, 32'd2);

    // addi.
    seq("addi", 5, '{8,8,8,8,8,0,0,0,0,0,0,0},
        '{1,1,1,1,0,0,0,0,0,0,0,0}, '{0,1,9,10,0,0,0,0,0,0,0,0});
    chk("addi_done_cnt", cnt_done, 32'd1);

    // Unsupported opcode.
    seq("illegal", 3, '{63,63,63,0,0,0,0,0,0,0,0,0},
        '{1,1,0,0,0,0,0,0,0,0,0,0}, '{0,1,0,0,0,0,0,0,0,0,0,0});
    chk("illegal_cnt", cnt_ill, 32'd1);
    chk("illegal_done_cnt", cnt_done, 32'd0);

    // Reset during a stalled MEMRD.
    seq("lwrst", 4, '{35,35,35,35,0,0,0,0,0,0,0,0},
        '{1,1,1,0,0,0,0,0,0,0,0,0}, '{0,1,2,3,0,0,0,0,0,0,0,0});
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("midrst_before", {28'd0, state}, 32'd3);
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("midrst_state", {28'd0, state}, 32'd0);
    chk("midrst_alusrcb", {30'd0, alusrcb}, 32'd1);
    chk("midrst_irw_pcw", {30'd0, irwrite, pcwrite}, 32'd0);
    chk("midrst_iord", {31'd0, iord}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
